pu_layer_sequencer: RTL and testbench

Parametrised layer sequencer for the processing unit (PU). On `start` it walks `num_layers` layers. For each layer it fetches the output-tile count from the layer-config store, then issues one `pe_start` per tile and waits for the PE array's `pe_done`. It sits between the top-level host control and the PE array / config RAM, and reports progress through `state`, `layer_idx` and `tile_idx`.

---
 rtl/pu_layer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pu_layer_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pu_layer_sequencer.sv
// pu_layer_sequencer
// -------------------
// Walks a run of layers for the processing unit. For each layer the tile count
// is read from the layer-config store, then one pe_start is issued per tile and
// the sequencer waits for pe_done before issuing the next tile.
//
// Optional feature macro: PU_SEQ_ABORT_EN
//   When defined, adds input 'abort' and output 'aborted'. An abort in any busy
//   state except DONE returns the sequencer to IDLE and clears the indices.
//   'aborted' pulses one cycle later, and no 'done' is issued for that run.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start, num_layers : begin a run of num_layers layers (sampled in IDLE only)
//   cfg_rd_req/addr   : one-cycle config read request for layer cfg_rd_addr
//   cfg_rd_valid/data : config response carrying the tile count of that layer
//   pe_start, pe_done : tile launch pulse / tile completion pulse
//   busy, done        : run in progress / one-cycle run-complete pulse
//   state, layer_idx, tile_idx : progress reporting
module pu_layer_sequencer #(
  parameter int LAYER_PARAM_WIDTH = 10,
  parameter int MAX_LAYERS        = 64,
  parameter int LAYER_ID_W        = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LAYER_ID_W:0]          num_layers,
  output logic                         cfg_rd_req,
  output logic [LAYER_ID_W-1:0]        cfg_rd_addr,
  input  logic                         cfg_rd_valid,
  input  logic [LAYER_PARAM_WIDTH-1:0] cfg_rd_data,
  output logic                         pe_start,
  input  logic                         pe_done,
`ifdef PU_SEQ_ABORT_EN
  input  logic                         abort,
  output logic                         aborted,
`endif
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   state,
  output logic [LAYER_ID_W-1:0]        layer_idx,
  output logic [LAYER_PARAM_WIDTH-1:0] tile_idx
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG_REQ  = 3'd1,
    S_CFG_WAIT = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT     = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  // n_lat is one bit wider than a layer index so it can hold MAX_LAYERS itself.
  localparam logic [LAYER_ID_W:0] MAX_L = (LAYER_ID_W+1)'(MAX_LAYERS);

  state_e                       state_q, state_d;
  logic [LAYER_ID_W-1:0]        layer_q, layer_d;
  logic [LAYER_PARAM_WIDTH-1:0] tile_q,  tile_d;
  logic [LAYER_PARAM_WIDTH-1:0] tiles_q, tiles_d;
  logic [LAYER_ID_W:0]          n_lat_q, n_lat_d;
`ifdef PU_SEQ_ABORT_EN
  logic                         aborted_q, aborted_d;
`endif

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    tile_d  = tile_q;
    tiles_d = tiles_q;
    n_lat_d = n_lat_q;
`ifdef PU_SEQ_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_lat_d = (num_layers > MAX_L) ? MAX_L : num_layers;
          layer_d = '0;
          tile_d  = '0;
          state_d = (num_layers == '0) ? S_DONE : S_CFG_REQ;
        end
      end
      S_CFG_REQ: state_d = S_CFG_WAIT;
      S_CFG_WAIT: begin
        if (cfg_rd_valid) begin
          tiles_d = cfg_rd_data;
          // A zero-tile layer is skipped without any pe_start.
          state_d = (cfg_rd_data == '0) ? S_NEXT : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (pe_done) begin
          if (tile_q == tiles_q - 1'b1) begin
            state_d = S_NEXT;
          end else begin
            tile_d  = tile_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_NEXT: begin
        if ({1'b0, layer_q} == n_lat_q - 1'b1) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + 1'b1;
          tile_d  = '0;
          state_d = S_CFG_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;  // encoding 7 is unreachable; recover to IDLE
    endcase
`ifdef PU_SEQ_ABORT_EN
    // Abort overrides whatever the case above decided for this cycle.
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d   = S_IDLE;
      layer_d   = '0;
      tile_d    = '0;
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      tile_q  <= '0;
      tiles_q <= '0;
      n_lat_q <= '0;
`ifdef PU_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      tile_q  <= tile_d;
      tiles_q <= tiles_d;
      n_lat_q <= n_lat_d;
`ifdef PU_SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Moore outputs decoded straight from the state register.
  assign cfg_rd_req  = (state_q == S_CFG_REQ);
  assign pe_start    = (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign state       = state_q;
  assign layer_idx   = layer_q;
  assign tile_idx    = tile_q;
  assign cfg_rd_addr = layer_q;
`ifdef PU_SEQ_ABORT_EN
  assign aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_pu_layer_sequencer.sv
// Self-checking bench for pu_layer_sequencer. A cycle-stepped responder plays
// the config store and the PE array with configurable latencies; the reference
// model predicts the ordered list of config addresses, the (layer, tile) list of
// pe_start pulses and the cycle of the done pulse from the per-layer tile table.
module tb_pu_layer_sequencer;
  localparam int LPW = 10;
  localparam int LIW = 6;
  localparam int MAXL = 64;

  logic           clk = 1'b0;
  logic           reset, start, cfg_rd_valid, pe_done;
  logic [LIW:0]   num_layers;
  logic [LPW-1:0] cfg_rd_data;
  logic           cfg_rd_req, pe_start, busy, done;
  logic [LIW-1:0] cfg_rd_addr, layer_idx;
  logic [LPW-1:0] tile_idx;
  logic [2:0]     state;
`ifdef PU_SEQ_ABORT_EN
  logic           abort, aborted;
`endif

  always #5 clk = ~clk;

  pu_layer_sequencer #(.LAYER_PARAM_WIDTH(LPW), .MAX_LAYERS(MAXL), .LAYER_ID_W(LIW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_layers(num_layers),
    .cfg_rd_req(cfg_rd_req), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_valid(cfg_rd_valid), .cfg_rd_data(cfg_rd_data),
    .pe_start(pe_start), .pe_done(pe_done),
`ifdef PU_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .state(state),
    .layer_idx(layer_idx), .tile_idx(tile_idx)
  );

  int n_total = 0;
  int n_pass  = 0;
  int tiles_tab[MAXL];
  int exp_addr[$], obs_addr[$], exp_pe[$], obs_pe[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: run to completion; 1: reset in WAIT of layer 1; 2: abort there.
  task automatic run(input int n, input int cfg_lat, input int pe_lat,
                     input bit noise, input int mode, input string tag);
    int cyc, cfg_cnt, pe_cnt, cfg_dat, done_cyc, req1_cyc, n_eff, exp_done;
    int busy_bad, addr_bad, addr_mis, pe_mis, bad;
    // reference model: straight from the per-layer rules and cycle costs
    n_eff = (n > MAXL) ? MAXL : n;
    exp_addr.delete(); exp_pe.delete(); obs_addr.delete(); obs_pe.delete();
    exp_done = 1;  // the DONE cycle itself
    for (int l = 0; l < n_eff; l++) begin
      exp_addr.push_back(l);
      for (int t = 0; t < tiles_tab[l]; t++) exp_pe.push_back(l * 2048 + t);
      exp_done += 2 + cfg_lat + tiles_tab[l] * (1 + pe_lat);  // CFG_REQ+NEXT, CFG_WAIT, tiles
    end
    num_layers = LIW'(0) | (LIW+1)'(n); start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; cfg_cnt = 0; pe_cnt = 0; cfg_dat = 0; done_cyc = -1; req1_cyc = -1;
    busy_bad = 0; addr_bad = 0;
    while (cyc < 20000) begin
      if (mode != 0 && state == 3'd4 && layer_idx == 1) begin
        start = 1'b0; pe_done = 1'b0; cfg_rd_valid = 1'b0;
        if (mode == 1) reset = 1'b1;
`ifdef PU_SEQ_ABORT_EN
        else abort = 1'b1;
`endif
        tick();
        reset = 1'b0;
`ifdef PU_SEQ_ABORT_EN
        abort = 1'b0;
        if (mode == 2) chk({tag, ".aborted"}, aborted, 1);
`endif
        chk({tag, ".state"}, state, 0);
        chk({tag, ".layer_idx"}, layer_idx, 0);
        chk({tag, ".tile_idx"}, tile_idx, 0);
        chk({tag, ".busy"}, busy, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
          if (done !== 1'b0 || state !== 3'd0) bad++;
          tick();
        end
        chk({tag, ".no_done_after"}, bad, 0);
        return;
      end
      if (busy !== 1'b1) busy_bad++;
      if (cfg_rd_req) begin
        if (req1_cyc < 0) req1_cyc = cyc;
        obs_addr.push_back(int'(cfg_rd_addr));
        if (cfg_rd_addr !== layer_idx) addr_bad++;
      end
      if (pe_start) obs_pe.push_back(int'(layer_idx) * 2048 + int'(tile_idx));
      if (done) begin done_cyc = cyc; break; end
      cfg_rd_valid = 1'b0; pe_done = 1'b0; start = 1'b0;
      cfg_rd_data = LPW'($urandom);
      if (cfg_cnt > 0) begin
        cfg_cnt--;
        if (cfg_cnt == 0) begin cfg_rd_valid = 1'b1; cfg_rd_data = LPW'(cfg_dat); end
      end
      if (cfg_rd_req) begin cfg_cnt = cfg_lat; cfg_dat = tiles_tab[cfg_rd_addr]; end
      if (pe_cnt > 0) begin
        pe_cnt--;
        if (pe_cnt == 0) pe_done = 1'b1;
      end
      if (pe_start) pe_cnt = pe_lat;
      if (noise) begin
        // pe_done where it must be ignored: CFG_WAIT and the ISSUE cycle
        if (state == 3'd2 || pe_start) pe_done = 1'($urandom_range(0, 1));
        if (state == 3'd4 && !pe_done) cfg_rd_valid = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        num_layers = (LIW+1)'($urandom);
      end
      tick();
      cyc++;
    end
    start = 1'b0; pe_done = 1'b0; cfg_rd_valid = 1'b0;
    addr_mis = 0; pe_mis = 0;
    foreach (exp_addr[i]) if (i >= obs_addr.size() || obs_addr[i] != exp_addr[i]) addr_mis++;
    foreach (exp_pe[i])   if (i >= obs_pe.size()   || obs_pe[i]   != exp_pe[i])   pe_mis++;
    chk({tag, ".done_cycle"}, done_cyc, exp_done);
    chk({tag, ".first_req_cycle"}, req1_cyc, (n_eff > 0) ? 1 : -1);
    chk({tag, ".cfg_reads"}, obs_addr.size(), exp_addr.size());
    chk({tag, ".cfg_addr_mis"}, addr_mis, 0);
    chk({tag, ".pe_starts"}, obs_pe.size(), exp_pe.size());
    chk({tag, ".pe_order_mis"}, pe_mis, 0);
    chk({tag, ".busy_gaps"}, busy_bad, 0);
    chk({tag, ".addr_vs_idx"}, addr_bad, 0);
    if (obs_addr.size() > 0) chk({tag, ".last_addr"}, obs_addr[$], n_eff - 1);
    tick();
    chk({tag, ".idle_after"}, state, 0);
    chk({tag, ".busy_after"}, busy, 0);
    chk({tag, ".done_width"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_layers = '0; cfg_rd_valid = 1'b0;
    cfg_rd_data = '0; pe_done = 1'b0;
`ifdef PU_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    chk("rst.state", state, 0);
    chk("rst.layer_idx", layer_idx, 0);
    chk("rst.tile_idx", tile_idx, 0);
    chk("rst.pulses", {busy, done, cfg_rd_req, pe_start}, 0);
    reset = 1'b0;
    tick();

    // Spurious responses in IDLE must not move the FSM.
    pe_done = 1'b1; cfg_rd_valid = 1'b1; cfg_rd_data = 10'd5;
    tick(); tick();
    chk("idle_spur.state", state, 0);
    chk("idle_spur.busy", busy, 0);
    pe_done = 1'b0; cfg_rd_valid = 1'b0;
    tick();

    tiles_tab[0] = 3; tiles_tab[1] = 1;
    run(2, 1, 4, 1'b0, 0, "basic");

    run(0, 1, 1, 1'b0, 0, "zero");

    tiles_tab[0] = 2; tiles_tab[1] = 0; tiles_tab[2] = 1;
    run(3, $urandom_range(1, 3), $urandom_range(1, 3), 1'b1, 0, "skip");

    for (int l = 0; l < MAXL; l++) tiles_tab[l] = $urandom_range(0, 2);
    run(100, 1, 1, 1'b0, 0, "clamp");
    run(64, 2, 1, 1'b1, 0, "max");

    for (int r = 0; r < 4; r++) begin
      for (int l = 0; l < MAXL; l++) tiles_tab[l] = $urandom_range(0, 4);
      run($urandom_range(1, 8), $urandom_range(1, 4), $urandom_range(1, 4), 1'b1, 0,
          $sformatf("rand%0d", r));
    end

    tiles_tab[0] = 1023;
    run(1, 1, 1, 1'b0, 0, "big_tiles");

    tiles_tab[0] = 2; tiles_tab[1] = 3;
    run(2, 1, 3, 1'b0, 1, "reset_mid");
    // Sequencer must still run normally after the mid-run reset.
    run(2, 2, 2, 1'b0, 0, "after_reset");

`ifdef PU_SEQ_ABORT_EN
    run(2, 1, 3, 1'b0, 2, "abort_mid");
    run(2, 1, 2, 1'b0, 0, "after_abort");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
